// File: rtl/mem_ctrler_pkg.sv
// Shared types and constants for the unified byte-wide RAM controller.
// Line size, address width and LSB access-length codes live here.
package mem_ctrler_pkg;

    localparam int DEF_LINE_BYTES = 16;
    localparam int DEF_ADDR_WIDTH = 32;

    typedef logic [DEF_ADDR_WIDTH-1:0]   addr_t;
    typedef logic [7:0]                  byte_t;
    typedef logic [DEF_LINE_BYTES*8-1:0] cache_line_t;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    // The reserved code 2'b11 behaves as a word access.
    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_B:   len_to_bytes = 3'd1;
            LEN_H:   len_to_bytes = 3'd2;
            default: len_to_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrler.sv
// Byte-wide RAM port owner: serialises icache line fills and LSB loads/stores
// into single-byte accesses and reassembles read data little-endian.
module mem_ctrler
    import mem_ctrler_pkg::*;
#(
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      reset_from_rob_bus,
    input  logic                      valid_from_inst_fetcher,
    input  logic [ADDR_WIDTH-1:0]     addr_from_inst_fetcher,
    output logic                      ready_to_inst_fetcher,
    output logic [LINE_BYTES*8-1:0]   cache_line_to_inst_fetcher,
    input  logic                      valid_from_lsb,
    input  logic                      is_write_from_lsb,
    input  logic [ADDR_WIDTH-1:0]     addr_from_lsb,
    input  logic [1:0]                len_from_lsb,
    input  logic [31:0]               data_from_lsb,
    output logic                      ready_to_lsb,
    output logic [31:0]               data_to_lsb,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [ADDR_WIDTH-1:0]     mem_a,
    output logic                      mem_wr
);

    localparam int CNT_W = $clog2(LINE_BYTES + 1);
    localparam int BUF_W = LINE_BYTES * 8;

    typedef enum logic [2:0] {
        ST_IDLE, ST_IF_READ, ST_LS_READ, ST_LS_WRITE, ST_DONE
    } state_t;

    state_t                r_state, w_state_next;
    logic [CNT_W-1:0]      r_cnt, r_len;
    logic [ADDR_WIDTH-1:0] r_mem_a;
    logic [7:0]            r_mem_dout, w_wbyte_next;
    logic                  r_mem_wr;
    logic [31:0]           r_wdata, r_lsb_data;
    logic [BUF_W-1:0]      r_buf, w_buf_ins, r_line;
    logic                  r_ready_if, r_ready_lsb;
    logic                  w_acc_lsb, w_acc_if, w_flush, w_rd_last, w_wr_last, w_mem_wr;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else if (rdy)
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_acc_lsb)
                    w_state_next = is_write_from_lsb ? ST_LS_WRITE : ST_LS_READ;
                else if (w_acc_if)
                    w_state_next = ST_IF_READ;
            end
            ST_IF_READ: begin
                if (w_flush)
                    w_state_next = ST_IDLE;
                else if (w_rd_last)
                    w_state_next = ST_DONE;
            end
            ST_LS_READ:  if (w_rd_last) w_state_next = ST_DONE;
            ST_LS_WRITE: if (w_wr_last) w_state_next = ST_DONE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so counter value c carries byte c-1.
    always_comb begin
        w_acc_lsb = (r_state == ST_IDLE) && valid_from_lsb;
        w_acc_if  = (r_state == ST_IDLE) && !valid_from_lsb &&
                    valid_from_inst_fetcher && !reset_from_rob_bus;
        w_flush   = (r_state == ST_IF_READ) && reset_from_rob_bus;
        w_rd_last = ((r_state == ST_IF_READ) || (r_state == ST_LS_READ)) && (r_cnt == r_len);
        w_wr_last = (r_state == ST_LS_WRITE) && (r_cnt == r_len - CNT_W'(1));
        w_mem_wr  = r_mem_wr && rdy && !rst;
        w_buf_ins = r_buf;
        for (int k = 0; k < LINE_BYTES; k++) begin
            if (r_cnt == CNT_W'(k + 1))
                w_buf_ins[8*k +: 8] = mem_din;
        end
        case (r_cnt[1:0])
            2'd0:    w_wbyte_next = r_wdata[15:8];
            2'd1:    w_wbyte_next = r_wdata[23:16];
            2'd2:    w_wbyte_next = r_wdata[31:24];
            default: w_wbyte_next = r_wdata[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_len       <= '0;
            r_mem_a     <= '0;
            r_mem_dout  <= '0;
            r_mem_wr    <= 1'b0;
            r_wdata     <= '0;
            r_buf       <= '0;
            r_line      <= '0;
            r_lsb_data  <= '0;
            r_ready_if  <= 1'b0;
            r_ready_lsb <= 1'b0;
        end else if (rdy) begin
            r_ready_if  <= 1'b0;
            r_ready_lsb <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_acc_lsb) begin
                        r_mem_a    <= addr_from_lsb;
                        r_len      <= CNT_W'(len_to_bytes(len_from_lsb));
                        r_wdata    <= data_from_lsb;
                        r_cnt      <= '0;
                        r_buf      <= '0;
                        r_mem_wr   <= is_write_from_lsb;
                        r_mem_dout <= data_from_lsb[7:0];
                    end else if (w_acc_if) begin
                        r_mem_a <= addr_from_inst_fetcher;
                        r_len   <= CNT_W'(LINE_BYTES);
                        r_cnt   <= '0;
                        r_buf   <= '0;
                    end
                end
                ST_IF_READ, ST_LS_READ: begin
                    if (w_flush) begin
                        r_cnt <= '0;
                    end else begin
                        r_buf <= w_buf_ins;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt < r_len - CNT_W'(1))
                            r_mem_a <= r_mem_a + ADDR_WIDTH'(1);
                        if (w_rd_last && r_state == ST_IF_READ) begin
                            r_line     <= w_buf_ins;
                            r_ready_if <= 1'b1;
                        end else if (w_rd_last) begin
                            r_lsb_data  <= w_buf_ins[31:0];
                            r_ready_lsb <= 1'b1;
                        end
                    end
                end
                ST_LS_WRITE: begin
                    if (w_wr_last) begin
                        r_mem_wr    <= 1'b0;
                        r_ready_lsb <= 1'b1;
                    end else begin
                        r_mem_a    <= r_mem_a + ADDR_WIDTH'(1);
                        r_mem_dout <= w_wbyte_next;
                        r_cnt      <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_a                      = r_mem_a;
    assign mem_dout                   = r_mem_dout;
    assign mem_wr                     = w_mem_wr;
    assign ready_to_inst_fetcher      = r_ready_if;
    assign cache_line_to_inst_fetcher = r_line;
    assign ready_to_lsb               = r_ready_lsb;
    assign data_to_lsb                = r_lsb_data;

endmodule

// File: tb/tb_mem_ctrler.sv
// Directed bench for mem_ctrler with a 1 KiB byte RAM model (one-cycle read
// latency, preset to ram[a] = a[7:0], sharing the global enable rdy).
module tb_mem_ctrler;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rdy = 1'b1;
    logic         reset_from_rob_bus = 1'b0;
    logic         valid_from_inst_fetcher = 1'b0;
    logic [31:0]  addr_from_inst_fetcher = '0;
    logic         ready_to_inst_fetcher;
    logic [127:0] cache_line_to_inst_fetcher;
    logic         valid_from_lsb = 1'b0;
    logic         is_write_from_lsb = 1'b0;
    logic [31:0]  addr_from_lsb = '0;
    logic [1:0]   len_from_lsb = 2'b00;
    logic [31:0]  data_from_lsb = '0;
    logic         ready_to_lsb;
    logic [31:0]  data_to_lsb;
    logic [7:0]   mem_din;
    logic [7:0]   mem_dout;
    logic [31:0]  mem_a;
    logic         mem_wr;

    logic         tb_init = 1'b0;
    logic [7:0]   ram [0:1023];
    int           n_cmp = 0;
    int           n_err = 0;

    mem_ctrler dut (
        .clk(clk), .rst(rst), .rdy(rdy), .reset_from_rob_bus(reset_from_rob_bus),
        .valid_from_inst_fetcher(valid_from_inst_fetcher),
        .addr_from_inst_fetcher(addr_from_inst_fetcher),
        .ready_to_inst_fetcher(ready_to_inst_fetcher),
        .cache_line_to_inst_fetcher(cache_line_to_inst_fetcher),
        .valid_from_lsb(valid_from_lsb), .is_write_from_lsb(is_write_from_lsb),
        .addr_from_lsb(addr_from_lsb), .len_from_lsb(len_from_lsb),
        .data_from_lsb(data_from_lsb), .ready_to_lsb(ready_to_lsb),
        .data_to_lsb(data_to_lsb), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int a = 0; a < 1024; a++) ram[a] <= 8'(a);
        end else if (rdy) begin
            if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
            mem_din <= ram[mem_a[9:0]];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] line_from(input int base);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = 8'(base + k);
        return l;
    endfunction

    task automatic test_reset;
        rst = 1'b1; tb_init = 1'b1;
        tick; tick;
        tb_init = 1'b0;
        n_cmp += 7;
        if (ready_to_inst_fetcher !== 1'b0) begin n_err++; $display("FAIL reset_ready_if got %b want 0", ready_to_inst_fetcher); end
        if (ready_to_lsb !== 1'b0) begin n_err++; $display("FAIL reset_ready_lsb got %b want 0", ready_to_lsb); end
        if (mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr got %b want 0", mem_wr); end
        if (mem_a !== 32'h0) begin n_err++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
        if (mem_dout !== 8'h0) begin n_err++; $display("FAIL reset_mem_dout got %h want 0", mem_dout); end
        if (data_to_lsb !== 32'h0) begin n_err++; $display("FAIL reset_data_to_lsb got %h want 0", data_to_lsb); end
        if (cache_line_to_inst_fetcher !== 128'h0) begin n_err++; $display("FAIL reset_line got %h want 0", cache_line_to_inst_fetcher); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_if_read;
        valid_from_inst_fetcher = 1'b1; addr_from_inst_fetcher = 32'h100;
        tick;
        for (int c = 0; c < 17; c++) begin
            n_cmp++;
            if (c < 16 && (mem_a !== 32'h100 + 32'(c) || mem_wr !== 1'b0 || ready_to_inst_fetcher !== 1'b0)) begin
                n_err++; $display("FAIL if_read_step c=%0d got a=%h wr=%b rdy=%b want a=%h wr=0 rdy=0", c, mem_a, mem_wr, ready_to_inst_fetcher, 32'h100 + 32'(c));
            end else if (c == 16 && ready_to_inst_fetcher !== 1'b0) begin
                n_err++; $display("FAIL if_read_early got ready=%b want 0 at cycle 16", ready_to_inst_fetcher);
            end
            tick;
        end
        n_cmp += 2;
        if (ready_to_inst_fetcher !== 1'b1) begin n_err++; $display("FAIL if_read_ready got %b want 1 at cycle 17", ready_to_inst_fetcher); end
        if (cache_line_to_inst_fetcher !== line_from(32'h100)) begin n_err++; $display("FAIL if_read_line got %h want %h", cache_line_to_inst_fetcher, line_from(32'h100)); end
        valid_from_inst_fetcher = 1'b0;
        tick;
        n_cmp++;
        if (ready_to_inst_fetcher !== 1'b0) begin n_err++; $display("FAIL if_read_pulse_width got %b want 0", ready_to_inst_fetcher); end
    endtask

    task automatic test_lsb_write_read;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        valid_from_lsb = 1'b1; is_write_from_lsb = 1'b1; addr_from_lsb = 32'h20;
        len_from_lsb = 2'b10; data_from_lsb = 32'hDEADBEEF;
        tick;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem_wr !== 1'b1 || mem_a !== 32'h20 + 32'(i) || mem_dout !== exp_b[i] || ready_to_lsb !== 1'b0) begin
                n_err++; $display("FAIL store_byte i=%0d got wr=%b a=%h d=%h rdy=%b want wr=1 a=%h d=%h rdy=0", i, mem_wr, mem_a, mem_dout, ready_to_lsb, 32'h20 + 32'(i), exp_b[i]);
            end
            tick;
        end
        n_cmp++;
        if (mem_wr !== 1'b0 || ready_to_lsb !== 1'b1) begin n_err++; $display("FAIL store_done got wr=%b rdy=%b want wr=0 rdy=1", mem_wr, ready_to_lsb); end
        valid_from_lsb = 1'b0;
        tick;
        n_cmp++;
        if ({ram[35], ram[34], ram[33], ram[32]} !== 32'hDEADBEEF) begin n_err++; $display("FAIL store_ram got %h want deadbeef", {ram[35], ram[34], ram[33], ram[32]}); end
        valid_from_lsb = 1'b1; is_write_from_lsb = 1'b0; addr_from_lsb = 32'h22; len_from_lsb = 2'b01;
        tick;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (ready_to_lsb !== 1'b0 || mem_wr !== 1'b0) begin n_err++; $display("FAIL load_wait i=%0d got rdy=%b wr=%b want 0 0", i, ready_to_lsb, mem_wr); end
            tick;
        end
        n_cmp += 2;
        if (ready_to_lsb !== 1'b1) begin n_err++; $display("FAIL load_ready got %b want 1", ready_to_lsb); end
        if (data_to_lsb !== 32'h0000DEAD) begin n_err++; $display("FAIL load_half got %h want 0000dead", data_to_lsb); end
        valid_from_lsb = 1'b0;
        tick;
    endtask

    task automatic test_both_valid;
        int lsb_n = 0, if_n = 0, lsb_at = -1, if_at = -1;
        valid_from_lsb = 1'b1; is_write_from_lsb = 1'b0; addr_from_lsb = 32'h105; len_from_lsb = 2'b00;
        valid_from_inst_fetcher = 1'b1; addr_from_inst_fetcher = 32'h180;
        tick;
        for (int c = 0; c < 40; c++) begin
            if (ready_to_lsb) begin lsb_n++; lsb_at = c; valid_from_lsb = 1'b0; end
            if (ready_to_inst_fetcher) begin if_n++; if_at = c; valid_from_inst_fetcher = 1'b0; end
            tick;
        end
        valid_from_lsb = 1'b0; valid_from_inst_fetcher = 1'b0;
        n_cmp += 4;
        if (lsb_n !== 1 || lsb_at !== 2) begin n_err++; $display("FAIL both_lsb got pulses=%0d at=%0d want 1 at 2", lsb_n, lsb_at); end
        if (if_n !== 1 || if_at !== 21) begin n_err++; $display("FAIL both_if got pulses=%0d at=%0d want 1 at 21", if_n, if_at); end
        if (data_to_lsb !== 32'h05) begin n_err++; $display("FAIL both_lsb_data got %h want 00000005", data_to_lsb); end
        if (cache_line_to_inst_fetcher !== line_from(32'h180)) begin n_err++; $display("FAIL both_line got %h want %h", cache_line_to_inst_fetcher, line_from(32'h180)); end
    endtask

    task automatic test_flush;
        int if_n = 0, if_at = -1, wr_seen = 0;
        valid_from_inst_fetcher = 1'b1; addr_from_inst_fetcher = 32'h3F8;
        tick;
        for (int c = 0; c < 5; c++) begin
            if (mem_wr) wr_seen++;
            tick;
        end
        reset_from_rob_bus = 1'b1; valid_from_inst_fetcher = 1'b0;
        tick;
        reset_from_rob_bus = 1'b0;
        valid_from_inst_fetcher = 1'b1; addr_from_inst_fetcher = 32'h200;
        tick;
        for (int c = 0; c < 30; c++) begin
            if (mem_wr) wr_seen++;
            if (ready_to_inst_fetcher) begin if_n++; if_at = c; valid_from_inst_fetcher = 1'b0; end
            tick;
        end
        valid_from_inst_fetcher = 1'b0;
        n_cmp += 3;
        if (wr_seen !== 0) begin n_err++; $display("FAIL flush_mem_wr got %0d write cycles want 0", wr_seen); end
        if (if_n !== 1 || if_at !== 17) begin n_err++; $display("FAIL flush_ready got pulses=%0d at=%0d want 1 at 17", if_n, if_at); end
        if (cache_line_to_inst_fetcher !== line_from(32'h200)) begin n_err++; $display("FAIL flush_line got %h want %h", cache_line_to_inst_fetcher, line_from(32'h200)); end
    endtask

    task automatic test_rdy_stall;
        int if_n = 0, if_at = -1;
        valid_from_inst_fetcher = 1'b1; addr_from_inst_fetcher = 32'h100;
        tick;
        for (int c = 0; c < 5; c++) tick;
        rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            n_cmp++;
            if (mem_a !== 32'h105 || mem_wr !== 1'b0) begin n_err++; $display("FAIL stall_freeze s=%0d got a=%h wr=%b want a=00000105 wr=0", s, mem_a, mem_wr); end
            tick;
        end
        rdy = 1'b1;
        for (int c = 8; c < 40; c++) begin
            if (ready_to_inst_fetcher) begin if_n++; if_at = c; valid_from_inst_fetcher = 1'b0; end
            tick;
        end
        valid_from_inst_fetcher = 1'b0;
        n_cmp += 2;
        if (if_n !== 1 || if_at !== 20) begin n_err++; $display("FAIL stall_ready got pulses=%0d at=%0d want 1 at 20", if_n, if_at); end
        if (cache_line_to_inst_fetcher !== line_from(32'h100)) begin n_err++; $display("FAIL stall_line got %h want %h", cache_line_to_inst_fetcher, line_from(32'h100)); end
        valid_from_lsb = 1'b1; is_write_from_lsb = 1'b1; addr_from_lsb = 32'h60; len_from_lsb = 2'b00; data_from_lsb = 32'h000000A5;
        tick;
        rdy = 1'b0;
        #1;
        n_cmp++;
        if (mem_wr !== 1'b0) begin n_err++; $display("FAIL stall_wr_gate got %b want 0", mem_wr); end
        tick;
        rdy = 1'b1;
        #1;
        n_cmp++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h60) begin n_err++; $display("FAIL stall_wr_resume got wr=%b a=%h want 1 00000060", mem_wr, mem_a); end
        tick;
        n_cmp += 2;
        if (ready_to_lsb !== 1'b1) begin n_err++; $display("FAIL stall_wr_ready got %b want 1", ready_to_lsb); end
        if (ram[10'h60] !== 8'hA5) begin n_err++; $display("FAIL stall_wr_ram got %h want a5", ram[10'h60]); end
        valid_from_lsb = 1'b0;
        tick;
    endtask

    task automatic test_rst_mid_write;
        int lsb_n = 0, lsb_at = -1;
        valid_from_lsb = 1'b1; is_write_from_lsb = 1'b1; addr_from_lsb = 32'h40;
        len_from_lsb = 2'b10; data_from_lsb = 32'h11223344;
        tick;
        tick;
        tick;
        rst = 1'b1; valid_from_lsb = 1'b0;
        tick;
        n_cmp += 6;
        if (mem_wr !== 1'b0) begin n_err++; $display("FAIL rstw_mem_wr got %b want 0", mem_wr); end
        if (mem_a !== 32'h0) begin n_err++; $display("FAIL rstw_mem_a got %h want 0", mem_a); end
        if (mem_dout !== 8'h0) begin n_err++; $display("FAIL rstw_mem_dout got %h want 0", mem_dout); end
        if (ready_to_lsb !== 1'b0) begin n_err++; $display("FAIL rstw_ready got %b want 0", ready_to_lsb); end
        if (data_to_lsb !== 32'h0) begin n_err++; $display("FAIL rstw_data got %h want 0", data_to_lsb); end
        if (cache_line_to_inst_fetcher !== 128'h0) begin n_err++; $display("FAIL rstw_line got %h want 0", cache_line_to_inst_fetcher); end
        rst = 1'b0;
        n_cmp++;
        if ({ram[10'h43], ram[10'h42], ram[10'h41], ram[10'h40]} !== 32'h43423344) begin
            n_err++; $display("FAIL rstw_ram got %h want 43423344", {ram[10'h43], ram[10'h42], ram[10'h41], ram[10'h40]});
        end
        valid_from_lsb = 1'b1; is_write_from_lsb = 1'b0; addr_from_lsb = 32'h40; len_from_lsb = 2'b01;
        tick;
        for (int c = 0; c < 8; c++) begin
            if (ready_to_lsb) begin lsb_n++; lsb_at = c; valid_from_lsb = 1'b0; end
            tick;
        end
        valid_from_lsb = 1'b0;
        n_cmp += 2;
        if (lsb_n !== 1 || lsb_at !== 3) begin n_err++; $display("FAIL rstw_reload got pulses=%0d at=%0d want 1 at 3", lsb_n, lsb_at); end
        if (data_to_lsb !== 32'h00003344) begin n_err++; $display("FAIL rstw_reload_data got %h want 00003344", data_to_lsb); end
    endtask

    initial begin
        test_reset;
        test_if_read;
        test_lsb_write_read;
        test_both_valid;
        test_flush;
        test_rdy_stall;
        test_rst_mid_write;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_ctrler.md
Name: mem_ctrler

Overview:
- Sole owner of the byte-wide unified RAM port.
- Serves two clients:
  - inst_fetcher: cache-line reads on icache miss.
  - Load/store buffer (LSB): 1/2/4-byte reads and writes.
- Sequences each request into consecutive byte accesses, assembles the results little-endian, and returns them with a one-cycle ready pulse.
- Sits directly upstream of inst_fetcher's fill path.

Parameters:
- LINE_BYTES, 16, bytes per icache line; must match CACHE_LINE_TYPE.
- ADDR_WIDTH, 32, address width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- rdy  in  1  global enable; low freezes all state.
- reset_from_rob_bus  in  1  misprediction flush.
- valid_from_inst_fetcher  in  1  line-read request; held until ready.
- addr_from_inst_fetcher  in  ADDR_WIDTH  line base address.
- ready_to_inst_fetcher  out  1  one-cycle pulse, line valid.
- cache_line_to_inst_fetcher  out  LINE_BYTES*8  byte k at bits [8k+7:8k].
- valid_from_lsb  in  1  LSB request; held until ready.
- is_write_from_lsb  in  1  1 = store, 0 = load.
- addr_from_lsb  in  ADDR_WIDTH  byte address.
- len_from_lsb  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes; 11 reserved (treated as 4).
- data_from_lsb  in  32  store data; low bytes used.
- ready_to_lsb  out  1  one-cycle pulse, access done.
- data_to_lsb  out  32  load data, zero-extended.
- mem_din  in  8  RAM read data; one-cycle latency.
- mem_dout  out  8  RAM write data.
- mem_a  out  ADDR_WIDTH  RAM address.
- mem_wr  out  1  1 = write this cycle.

Behaviour:
- Reset (rst=1 at posedge):
  - state = IDLE.
  - All outputs 0, including mem_wr=0 and mem_a=0.
  - Byte counter and assembly registers cleared.
  - Reset overrides everything, including mid-transfer; a partially written store is abandoned.
- rdy=0: registers hold; mem_wr forced 0 combinationally.
- State machine: IDLE, IF_READ, LS_READ, LS_WRITE, DONE.
- IDLE arbitration: LSB has priority over the fetcher.
  - On the edge where valid_from_lsb=1: latch addr/len/data; go to LS_WRITE or LS_READ; cnt=0.
  - Else, if valid_from_inst_fetcher=1 and reset_from_rob_bus=0: latch addr; go to IF_READ; cnt=0.
- RAM read timing: mem_a driven in cycle c; mem_din holds that byte in cycle c+1.
- Reads (N = LINE_BYTES or LSB length):
  - Cycle i after acceptance (i = 0..N-1): mem_a = base+i, mem_wr=0.
  - Byte i is captured at the edge ending cycle i+1.
  - After byte N-1 is captured: assert ready for one cycle with full data; enter DONE.
  - Total: ready in cycle N+1 after the acceptance edge.
- Writes:
  - Cycle i (i = 0..len-1): mem_a = addr+i, mem_wr=1, mem_dout = data_from_lsb[8i+7:8i].
  - Cycle len: mem_wr=0, ready_to_lsb=1, enter DONE.
- Address arithmetic is modulo 2^ADDR_WIDTH; no alignment required; a line may straddle any boundary.
- DONE:
  - Ready outputs drop to 0; no request is accepted this cycle, which prevents a duplicate accept while the client drops valid.
  - Next edge returns to IDLE.
- Data outputs hold their last value until overwritten by the next transfer of the same client.
- reset_from_rob_bus:
  - In IF_READ: abort. Next state is IDLE, mem_wr=0, no ready pulse, partial line discarded.
  - In LS_READ, LS_WRITE, DONE: ignored; LSB traffic is never aborted by flush.
  - In IDLE: blocks fetcher acceptance that edge; LSB acceptance unaffected.
- Fetcher address changes mid-IF_READ without a flush: ignored; the latched address completes. inst_fetcher discards it by pc comparison.
- Between transfers (IDLE): mem_wr=0; mem_a holds the last value.

Decomposition:
- config.v (shared): ADDR_TYPE, BYTE_TYPE, CACHE_LINE_TYPE, LINE_BYTES, LSB length codes (LEN_B/LEN_H/LEN_W).
- The state encoding is local to the module.
- No sub-module: byte sequencing is a single counter shared by all states.

Test Plan:
- IF line read, addr=0x100, RAM[0x100+k]=k: mem_a steps 0x100..0x10F on consecutive cycles; ready_to_inst_fetcher pulses once, 17 cycles after accept; line bytes = 00..0F.
- LSB store, len=10, addr=0x20, data=0xDEADBEEF: four mem_wr=1 cycles writing EF, BE, AD, DE at 0x20..0x23; ready_to_lsb in cycle 4; then LSB load, len=01, addr=0x22 -> data_to_lsb=0x0000DEAD.
- Both clients valid in the same IDLE cycle: LSB served first; fetcher accepted on the edge after DONE; each ready pulses exactly once.
- reset_from_rob_bus asserted in cycle 5 of IF_READ: no ready pulse, mem_wr stays 0; a new fetch to 0x200 then completes normally.
- rst pulsed during cycle 2 of LS_WRITE: only two bytes written; all outputs 0 and state IDLE next cycle; no ready pulse.
- rdy held low for 3 cycles mid-IF_READ: mem_a frozen, mem_wr=0; completion delayed by exactly 3 cycles with correct line.
